// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
// UART 8N1 receiver: idle high, start 0, 8 data bits LSB first, stop 1.
// The start bit is confirmed at its midpoint, which rejects short glitches.
// Each data bit and the stop bit are sampled one full bit period after the
// previous sample, which places every sample near the middle of its bit.
// A bad stop bit reports a framing error. The receiver then waits for the
// line to return high before looking for the next start bit. Good bytes go
// into a one-entry valid/ready holding register. If that register is still
// occupied when a new byte arrives, the new byte is dropped and an overrun
// is reported.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   i_rx         asynchronous serial input, idle high
//   o_data       received byte, stable while o_valid=1
//   o_valid      o_data holds an unconsumed byte
//   i_ready      consumer takes o_data when o_valid && i_ready at posedge
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: good byte dropped, holding register full
//   o_busy       receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic             r_rxMeta;
  logic             r_rxSync;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shreg;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frameErr;
  logic             r_overrun;

  // Two-flop synchronizer. Both flops reset high so that reset does not
  // look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= i_rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // Receive FSM and output register. A consume clears valid by default.
  // A delivery in the STOP state takes priority over that clear. This
  // keeps valid high and loads the new byte when a consume and a delivery
  // happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= 3'd0;
      r_shreg    <= 8'h00;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
      if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rxSync) begin
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (!r_rxSync) begin
              r_state  <= DATA;
              r_bitIdx <= 3'd0;
            end else begin
              // The line went high before mid-start: treat it as a glitch.
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt             <= '0;
            r_shreg[r_bitIdx] <= r_rxSync;
            if (r_bitIdx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_rxSync) begin
              r_state <= IDLE;
              if (!r_valid || i_ready) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frameErr <= 1'b1;
              r_state    <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait for the line to go high again. Without this, a line held
          // low would be decoded as a series of all-zero frames.
          r_cnt <= '0;
          if (r_rxSync) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frameErr;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_framed
// Self-checking bench for uart_rx_framed with CLKS_PER_BIT=16.
// The directed scenarios cover these cases:
//   - a single correct frame
//   - a start-bit glitch
//   - a bad stop bit followed by a line held low
//   - an overrun
//   - ready held high
//   - reset in the middle of a frame
// A random phase follows. It sends random bytes with random stop-bit
// validity. For each frame, the expected result (delivered byte or framing
// error) is derived directly from the frame content.
// ---------------------------------------------------------------------------
module tb_uart_rx_framed;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int NOM  = HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int checkCount  = 0;
  int errorCount  = 0;
  int ferrCnt     = 0;
  int ovrCnt      = 0;
  int bothCnt     = 0;
  int validCycles = 0;
  logic [7:0] consumedQ[$];

  uart_rx_framed #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (i_rx),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor. It samples on the falling edge, midway between active
  // edges, and records handshakes and error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) consumedQ.push_back(o_data);
      if (o_frame_err) ferrCnt++;
      if (o_overrun) ovrCnt++;
      if (o_frame_err && o_overrun) bothCnt++;
      if (o_valid) validCycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a whole frame and leaves the line at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    i_rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      waitCycles(CPB);
    end
    i_rx = stopBit;
    waitCycles(CPB);
  endtask

  task automatic consumeOne();
    i_ready = 1'b1;
    waitCycles(1);
    i_ready = 1'b0;
  endtask

  int         lat;
  int         f0, o0, v0;
  logic [7:0] expBytes[3];
  logic [7:0] rb;
  logic       rs;

  initial begin
    rst_n   = 1'b0;
    i_rx    = 1'b1;
    i_ready = 1'b0;
    waitCycles(3);
    checkOutput("rstData", o_data, 8'h00);
    checkOutput("rstValid", o_valid, 1'b0);
    checkOutput("rstFerr", o_frame_err, 1'b0);
    checkOutput("rstOvr", o_overrun, 1'b0);
    checkOutput("rstBusy", o_busy, 1'b0);
    rst_n = 1'b1;
    waitCycles(5);

    // Single frame with latency measurement
    f0 = ferrCnt; o0 = ovrCnt;
    lat = 0;
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        for (int c = 1; c <= 400; c++) begin
          @(posedge clk); #1;
          if (o_valid) begin
            lat = c;
            break;
          end
        end
      end
    join
    i_rx = 1'b1;
    waitCycles(4);
    checkOutput("t1Latency", (lat >= NOM && lat <= NOM + 6), 1);
    checkOutput("t1Valid", o_valid, 1'b1);
    checkOutput("t1Data", o_data, 8'hA5);
    checkOutput("t1Ferr", ferrCnt - f0, 0);
    checkOutput("t1Ovr", ovrCnt - o0, 0);
    checkOutput("t1Busy", o_busy, 1'b0);
    consumeOne();
    waitCycles(1);
    checkOutput("t1Consumed", o_valid, 1'b0);

    // Start-bit glitch
    f0 = ferrCnt; v0 = validCycles;
    i_rx = 1'b0;
    waitCycles(4);
    i_rx = 1'b1;
    waitCycles(2);
    checkOutput("t2BusyPulse", o_busy, 1'b1);
    waitCycles(30);
    checkOutput("t2BusyIdle", o_busy, 1'b0);
    checkOutput("t2NoValid", validCycles - v0, 0);
    checkOutput("t2NoFerr", ferrCnt - f0, 0);
    applyStimulus(8'h5A, 1'b1);
    waitCycles(4);
    checkOutput("t2Valid", o_valid, 1'b1);
    checkOutput("t2Data", o_data, 8'h5A);
    consumeOne();
    waitCycles(2);

    // Bad stop bit, then a held-low line
    f0 = ferrCnt; v0 = validCycles;
    applyStimulus(8'h0F, 1'b0);
    waitCycles(40);
    checkOutput("t3BusyLow", o_busy, 1'b1);
    checkOutput("t3FerrOne", ferrCnt - f0, 1);
    checkOutput("t3NoValid", validCycles - v0, 0);
    i_rx = 1'b1;
    waitCycles(10);
    checkOutput("t3BusyIdle", o_busy, 1'b0);
    checkOutput("t3FerrStill", ferrCnt - f0, 1);
    applyStimulus(8'h81, 1'b1);
    waitCycles(4);
    checkOutput("t3Valid", o_valid, 1'b1);
    checkOutput("t3Data", o_data, 8'h81);
    consumeOne();
    waitCycles(2);

    // Overrun with ready held low
    o0 = ovrCnt;
    applyStimulus(8'h3C, 1'b1);
    waitCycles(4);
    checkOutput("t4Valid", o_valid, 1'b1);
    checkOutput("t4Data1", o_data, 8'h3C);
    applyStimulus(8'hC3, 1'b1);
    waitCycles(4);
    checkOutput("t4OvrOne", ovrCnt - o0, 1);
    checkOutput("t4DataKept", o_data, 8'h3C);
    checkOutput("t4ValidKept", o_valid, 1'b1);
    consumeOne();
    waitCycles(1);
    checkOutput("t4Cleared", o_valid, 1'b0);
    checkOutput("t4DataHold", o_data, 8'h3C);

    // Ready held high: three single-cycle valid pulses
    consumedQ.delete();
    o0 = ovrCnt; v0 = validCycles;
    expBytes[0] = 8'h01; expBytes[1] = 8'h80; expBytes[2] = 8'hFF;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(expBytes[k], 1'b1);
      waitCycles(4);
    end
    i_ready = 1'b0;
    checkOutput("t5Count", consumedQ.size(), 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t5Byte%0d", k),
                  (k < consumedQ.size()) ? {24'h0, consumedQ[k]} : 32'hDEAD,
                  {24'h0, expBytes[k]});
    end
    checkOutput("t5ValidCycles", validCycles - v0, 3);
    checkOutput("t5NoOvr", ovrCnt - o0, 0);

    // Reset during data bit 4 of 8'h77
    consumedQ.delete();
    i_rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 4; i++) begin
      i_rx = 1'(8'h77 >> i);
      waitCycles(CPB);
    end
    i_rx = 1'b1;
    waitCycles(8);
    rst_n = 1'b0;
    #1;
    checkOutput("t6RstData", o_data, 8'h00);
    checkOutput("t6RstValid", o_valid, 1'b0);
    checkOutput("t6RstBusy", o_busy, 1'b0);
    checkOutput("t6RstFerr", o_frame_err, 1'b0);
    checkOutput("t6RstOvr", o_overrun, 1'b0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(CPB * 6);
    checkOutput("t6NoStale", o_valid, 1'b0);
    applyStimulus(8'h12, 1'b1);
    waitCycles(4);
    checkOutput("t6Valid", o_valid, 1'b1);
    checkOutput("t6Data", o_data, 8'h12);
    consumeOne();
    waitCycles(2);
    checkOutput("t6OnlyOne", consumedQ.size(), 1);

    // Random frames with ready high. A frame with a good stop bit must
    // hand over exactly its own byte; a bad stop bit must give exactly one
    // framing error and no byte.
    i_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      consumedQ.delete();
      f0 = ferrCnt;
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      applyStimulus(rb, rs);
      i_rx = 1'b1;
      waitCycles(CPB + $urandom_range(0, CPB));
      if (rs) begin
        checkOutput($sformatf("rndCount%0d", n), consumedQ.size(), 1);
        checkOutput($sformatf("rndByte%0d", n),
                    (consumedQ.size() > 0) ? {24'h0, consumedQ[0]} : 32'hDEAD,
                    {24'h0, rb});
        checkOutput($sformatf("rndNoFerr%0d", n), ferrCnt - f0, 0);
      end else begin
        checkOutput($sformatf("rndNoByte%0d", n), consumedQ.size(), 0);
        checkOutput($sformatf("rndFerr%0d", n), ferrCnt - f0, 1);
      end
    end
    i_ready = 1'b0;
    checkOutput("neverBoth", bothCnt, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
